// File: rtl/inert_spi_resp.sv
// SPI mode-0 responder standing in for the inertial sensor: 16-bit frames,
// small register file, and coherent pitch/roll/yaw capture with a data-ready INT.
module inert_spi_resp (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        INT,
  input  logic [15:0] ptch_smpl,
  input  logic [15:0] roll_smpl,
  input  logic [15:0] yaw_smpl,
  input  logic        smpl_vld
);

  localparam logic [6:0] ADDR_INT1_CTRL = 7'h0D;
  localparam logic [6:0] ADDR_WHO_AM_I  = 7'h0F;
  localparam logic [6:0] ADDR_CTRL1_XL  = 7'h10;
  localparam logic [6:0] ADDR_CTRL2_G   = 7'h11;
  localparam logic [6:0] ADDR_YAW_H     = 7'h27;
  localparam logic [7:0] WHO_AM_I_VAL   = 8'h6A;

  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v == 5'd16) ? v : v + 5'd1;
  endfunction

  logic        ss_p0, ss_p1, ss_p2;
  logic        sclk_p0, sclk_p1, sclk_p2;
  logic        mosi_p0, mosi_p1;
  logic        sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic        active;
  logic [4:0]  bit_cnt;
  logic [15:0] rx_shft;
  logic [7:0]  tx_byte;
  logic [7:0]  int1_ctrl, ctrl1_xl, ctrl2_g;
  logic [15:0] ptch, roll, yaw;
  logic [15:0] ptch_pnd, roll_pnd, yaw_pnd;
  logic        pend;
  logic [7:0]  rd_data;
  logic        done, wr, rd_yaw_h, ld;
  logic [15:0] ptch_ld, roll_ld, yaw_ld;

  // Stage p0..p2: pin synchronizers plus a third flop for edge detection.
  // Left unreset so a reset with SS_n held low does not fake a frame start.
  always_ff @(posedge clk) begin
    ss_p0   <= SS_n;
    ss_p1   <= ss_p0;
    ss_p2   <= ss_p1;
    sclk_p0 <= SCLK;
    sclk_p1 <= sclk_p0;
    sclk_p2 <= sclk_p1;
    mosi_p0 <= MOSI;
    mosi_p1 <= mosi_p0;
  end

  assign sclk_rise = sclk_p1 & ~sclk_p2;
  assign sclk_fall = ~sclk_p1 & sclk_p2;
  assign ss_fall   = ~ss_p1 & ss_p2;
  assign ss_rise   = ss_p1 & ~ss_p2;

  always_comb begin
    rd_data = 8'h00;
    case (rx_shft[6:0])
      ADDR_INT1_CTRL: rd_data = int1_ctrl;
      ADDR_WHO_AM_I:  rd_data = WHO_AM_I_VAL;
      ADDR_CTRL1_XL:  rd_data = ctrl1_xl;
      ADDR_CTRL2_G:   rd_data = ctrl2_g;
      7'h22:          rd_data = ptch[7:0];
      7'h23:          rd_data = ptch[15:8];
      7'h24:          rd_data = roll[7:0];
      7'h25:          rd_data = roll[15:8];
      7'h26:          rd_data = yaw[7:0];
      7'h27:          rd_data = yaw[15:8];
      default:        rd_data = 8'h00;
    endcase
  end

  // Frame stage: shift on SCLK rise, drive the response byte on SCLK fall.
  // active stays low after a mid-frame reset until the next SS_n fall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active  <= 1'b0;
      bit_cnt <= 5'd0;
      rx_shft <= 16'h0000;
      tx_byte <= 8'h00;
    end else if (ss_fall) begin
      active  <= 1'b1;
      bit_cnt <= 5'd0;
      rx_shft <= 16'h0000;
      tx_byte <= 8'h00;
    end else begin
      if (ss_rise)
        active <= 1'b0;
      if (active && !ss_p1) begin
        if (sclk_rise) begin
          rx_shft <= {rx_shft[14:0], mosi_p1};
          bit_cnt <= sat_inc(bit_cnt);
        end
        if (sclk_fall) begin
          if (bit_cnt == 5'd8)
            tx_byte <= rx_shft[7] ? rd_data : 8'h00;
          else if (bit_cnt >= 5'd9 && bit_cnt <= 5'd15)
            tx_byte <= {tx_byte[6:0], 1'b0};
        end
      end
    end
  end

  assign MISO = ~ss_p1 & tx_byte[7];

  assign done     = ss_rise & active & (bit_cnt == 5'd16);
  assign wr       = done & ~rx_shft[15];
  assign rd_yaw_h = done & rx_shft[15] & (rx_shft[14:8] == ADDR_YAW_H);

  // A direct sample outside a frame takes priority over the pending copy.
  always_comb begin
    ld      = (smpl_vld & ss_p1) | (ss_rise & pend);
    ptch_ld = ptch_pnd;
    roll_ld = roll_pnd;
    yaw_ld  = yaw_pnd;
    if (smpl_vld & ss_p1) begin
      ptch_ld = ptch_smpl;
      roll_ld = roll_smpl;
      yaw_ld  = yaw_smpl;
    end
  end

  // Register stage: writes, sample capture and interrupt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      int1_ctrl <= 8'h00;
      ctrl1_xl  <= 8'h00;
      ctrl2_g   <= 8'h00;
      ptch      <= 16'h0000;
      roll      <= 16'h0000;
      yaw       <= 16'h0000;
      ptch_pnd  <= 16'h0000;
      roll_pnd  <= 16'h0000;
      yaw_pnd   <= 16'h0000;
      pend      <= 1'b0;
      INT       <= 1'b0;
    end else begin
      if (ld) begin
        ptch <= ptch_ld;
        roll <= roll_ld;
        yaw  <= yaw_ld;
      end
      if (smpl_vld && !ss_p1) begin
        ptch_pnd <= ptch_smpl;
        roll_pnd <= roll_smpl;
        yaw_pnd  <= yaw_smpl;
        pend     <= 1'b1;
      end else if (ss_rise) begin
        pend <= 1'b0;
      end
      if (wr) begin
        case (rx_shft[14:8])
          ADDR_INT1_CTRL: int1_ctrl <= rx_shft[7:0];
          ADDR_CTRL1_XL:  ctrl1_xl  <= rx_shft[7:0];
          ADDR_CTRL2_G:   ctrl2_g   <= rx_shft[7:0];
          default: ;
        endcase
      end
      if (ld && int1_ctrl[1])
        INT <= 1'b1;
      else if (rd_yaw_h || (wr && rx_shft[14:8] == ADDR_INT1_CTRL && !rx_shft[1]))
        INT <= 1'b0;
    end
  end

endmodule
